// File: rtl/rf_bank_sched_if.sv
// Request, write-back and RF bank-port bundle for the 4-bank register file scheduler.
// master: request/CDB side driving req_* and wr_*; slave: the scheduler.
// Signals: req_valid/bank/row/ocid, req_ready, wr_valid/bank/row/data, wr_ready,
//   bank_rd, bank_wr, bank_addr, bank_ocid, bank_wdata, q_empty.
interface rf_bank_sched_if #(
  parameter int ROW_W  = 3,
  parameter int OCID_W = 4,
  parameter int DATA_W = 256
);
  logic                  req_valid;
  logic [1:0]            req_bank;
  logic [ROW_W-1:0]      req_row;
  logic [OCID_W-1:0]     req_ocid;
  logic                  req_ready;
  logic                  wr_valid;
  logic [1:0]            wr_bank;
  logic [ROW_W-1:0]      wr_row;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_ready;
  logic [3:0]            bank_rd;
  logic [3:0]            bank_wr;
  logic [4*ROW_W-1:0]    bank_addr;
  logic [4*OCID_W-1:0]   bank_ocid;
  logic [DATA_W-1:0]     bank_wdata;
  logic [3:0]            q_empty;

  modport master (
    output req_valid, req_bank, req_row, req_ocid,
    output wr_valid, wr_bank, wr_row, wr_data,
    input  req_ready, wr_ready,
    input  bank_rd, bank_wr, bank_addr, bank_ocid, bank_wdata, q_empty
  );

  modport slave (
    input  req_valid, req_bank, req_row, req_ocid,
    input  wr_valid, wr_bank, wr_row, wr_data,
    output req_ready, wr_ready,
    output bank_rd, bank_wr, bank_addr, bank_ocid, bank_wdata, q_empty
  );
endinterface

// File: rtl/rf_bank_sched.sv
// Per-bank RF scheduler: queues reads per bank, merges CDB writes, one access per bank per cycle.
// Latency: write taken in T strobes in T+1; uncontested read enqueued in T strobes in T+2.
// Backpressure: req_ready drops when the target bank FIFO is full; wr_ready drops only when a
//   starved read is forced onto the written bank.
// Ports: clk, rst (async active-low), io (rf_bank_sched_if.slave).

// Small generic FIFO; caller guarantees no push when full and no pop when empty.
module rf_bank_sched_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop_vld,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_vld) wptr <= wptr + 1'b1;
      if (pop_vld)  rptr <= rptr + 1'b1;
      case ({push_vld, pop_vld})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem[wptr] <= push_dat;
  end

  assign head_dat = mem[rptr];
endmodule

module rf_bank_sched #(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 3,
  parameter int ROW_W      = 3,
  parameter int OCID_W     = 4,
  parameter int DATA_W     = 256
) (
  input logic            clk,
  input logic            rst,
  rf_bank_sched_if.slave io
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_LIM + 1);
  localparam int ENT_W = ROW_W + OCID_W;

  typedef enum logic [1:0] {
    G_IDLE,
    G_WR,
    G_RD
  } grant_e;

  logic [CNT_W-1:0]  cnt       [4];
  logic [ENT_W-1:0]  head      [4];
  logic [ST_W-1:0]   starve    [4];
  logic [ST_W-1:0]   starve_nxt[4];
  grant_e            grant     [4];
  logic [3:0]        empty;
  logic [3:0]        force_rd;
  logic [3:0]        push;
  logic [3:0]        grant_w;
  logic [3:0]        grant_r;
  logic              req_ready;

  logic [3:0]          bank_rd_q;
  logic [3:0]          bank_wr_q;
  logic [4*ROW_W-1:0]  bank_addr_q;
  logic [4*OCID_W-1:0] bank_ocid_q;
  logic [DATA_W-1:0]   bank_wdata_q;

  // Full check looks at the registered count only, so a same-cycle pop never frees a slot.
  assign req_ready = (cnt[io.req_bank] != CNT_W'(DEPTH));

  for (genvar b = 0; b < 4; b++) begin : g_bank
    assign empty[b]    = (cnt[b] == '0);
    // A bank whose waiting read has lost STARVE_LIM times in a row refuses the write.
    assign force_rd[b] = (starve[b] == ST_W'(STARVE_LIM)) && !empty[b];
    assign push[b]     = io.req_valid && req_ready && (io.req_bank == 2'(b));
    assign grant_w[b]  = (grant[b] == G_WR);
    assign grant_r[b]  = (grant[b] == G_RD);

    rf_bank_sched_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (push[b]),
      .push_dat ({io.req_row, io.req_ocid}),
      .pop_vld  (grant_r[b]),
      .head_dat (head[b]),
      .count    (cnt[b])
    );
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      grant[b]      = G_IDLE;
      starve_nxt[b] = '0;
      if (io.wr_valid && (io.wr_bank == 2'(b)) && !force_rd[b]) begin
        grant[b] = G_WR;
        if (!empty[b]) begin
          starve_nxt[b] = (starve[b] == ST_W'(STARVE_LIM)) ? starve[b] : starve[b] + 1'b1;
        end
      end else if (!empty[b]) begin
        grant[b] = G_RD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 4; b++) starve[b] <= '0;
      bank_rd_q    <= '0;
      bank_wr_q    <= '0;
      bank_addr_q  <= '0;
      bank_ocid_q  <= '0;
      bank_wdata_q <= '0;
    end else begin
      bank_rd_q <= grant_r;
      bank_wr_q <= grant_w;
      for (int b = 0; b < 4; b++) begin
        starve[b] <= starve_nxt[b];
        // Address/ocid of an unstrobed bank keep their last value.
        if (grant_w[b]) begin
          bank_addr_q[b*ROW_W +: ROW_W] <= io.wr_row;
        end else if (grant_r[b]) begin
          bank_addr_q[b*ROW_W +: ROW_W]   <= head[b][ENT_W-1 -: ROW_W];
          bank_ocid_q[b*OCID_W +: OCID_W] <= head[b][OCID_W-1:0];
        end
      end
      // Only one write port exists, so at most one grant_w bit is set.
      if (|grant_w) bank_wdata_q <= io.wr_data;
    end
  end

  assign io.req_ready  = req_ready;
  assign io.wr_ready   = !force_rd[io.wr_bank];
  assign io.bank_rd    = bank_rd_q;
  assign io.bank_wr    = bank_wr_q;
  assign io.bank_addr  = bank_addr_q;
  assign io.bank_ocid  = bank_ocid_q;
  assign io.bank_wdata = bank_wdata_q;
  assign io.q_empty    = empty;
endmodule

// File: tb/tb_rf_bank_sched.sv
module tb_rf_bank_sched;
  localparam int DEPTH  = 4;
  localparam int LIM    = 3;
  localparam int ROW_W  = 3;
  localparam int OCID_W = 4;
  localparam int DATA_W = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_bank_sched_if #(.ROW_W(ROW_W), .OCID_W(OCID_W), .DATA_W(DATA_W)) sif ();

  rf_bank_sched #(
    .DEPTH(DEPTH), .STARVE_LIM(LIM), .ROW_W(ROW_W), .OCID_W(OCID_W), .DATA_W(DATA_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (sif)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per-bank request queues and "losses in a row" counters.
  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [OCID_W-1:0] ocid;
  } rd_req_t;

  rd_req_t             mq[4][$];
  int                  mstarve[4];
  logic [3:0]          m_rd, m_wr;
  logic [4*ROW_W-1:0]  m_addr;
  logic [4*OCID_W-1:0] m_ocid;
  logic [DATA_W-1:0]   m_wdata;
  logic                obs_req_ready, obs_wr_ready;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      mq[b].delete();
      mstarve[b] = 0;
    end
    m_rd = '0; m_wr = '0; m_addr = '0; m_ocid = '0; m_wdata = '0;
  endtask

  function automatic logic [3:0] m_empty();
    logic [3:0] r;
    for (int b = 0; b < 4; b++) r[b] = (mq[b].size() == 0);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic drive_idle();
    sif.req_valid = 1'b0; sif.req_bank = '0; sif.req_row = '0; sif.req_ocid = '0;
    sif.wr_valid  = 1'b0; sif.wr_bank  = '0; sif.wr_row  = '0; sif.wr_data  = '0;
  endtask

  // One cycle: called just after a rising edge; drives, checks readies, advances model,
  // crosses the edge and checks the registered outputs.
  task automatic step(input logic rv, input logic [1:0] rb, input logic [ROW_W-1:0] rr,
                      input logic [OCID_W-1:0] ro, input logic wv, input logic [1:0] wb,
                      input logic [ROW_W-1:0] wrow, input logic [DATA_W-1:0] wd);
    logic [3:0] frc;
    logic       exp_rr, exp_wrr;
    rd_req_t    e;
    sif.req_valid = rv; sif.req_bank = rb; sif.req_row = rr; sif.req_ocid = ro;
    sif.wr_valid  = wv; sif.wr_bank  = wb; sif.wr_row  = wrow; sif.wr_data = wd;
    #2;
    for (int b = 0; b < 4; b++) frc[b] = (mstarve[b] == LIM) && (mq[b].size() != 0);
    exp_rr  = (mq[rb].size() != DEPTH);
    exp_wrr = !frc[wb];
    obs_req_ready = sif.req_ready;
    obs_wr_ready  = sif.wr_ready;
    check("req_ready", DATA_W'(obs_req_ready), DATA_W'(exp_rr));
    check("wr_ready", DATA_W'(obs_wr_ready), DATA_W'(exp_wrr));
    m_rd = '0;
    m_wr = '0;
    for (int b = 0; b < 4; b++) begin
      if (wv && int'(wb) == b && !frc[b]) begin
        m_wr[b] = 1'b1;
        m_addr[b*ROW_W +: ROW_W] = wrow;
        m_wdata = wd;
        if (mq[b].size() != 0 && mstarve[b] < LIM) mstarve[b]++;
      end else if (mq[b].size() != 0) begin
        e = mq[b].pop_front();
        m_rd[b] = 1'b1;
        m_addr[b*ROW_W +: ROW_W]   = e.row;
        m_ocid[b*OCID_W +: OCID_W] = e.ocid;
        mstarve[b] = 0;
      end else begin
        mstarve[b] = 0;
      end
    end
    if (rv && exp_rr) begin
      e.row  = rr;
      e.ocid = ro;
      mq[rb].push_back(e);
    end
    @(posedge clk);
    #1;
    check("bank_rd", DATA_W'(sif.bank_rd), DATA_W'(m_rd));
    check("bank_wr", DATA_W'(sif.bank_wr), DATA_W'(m_wr));
    check("bank_addr", DATA_W'(sif.bank_addr), DATA_W'(m_addr));
    check("bank_ocid", DATA_W'(sif.bank_ocid), DATA_W'(m_ocid));
    check("bank_wdata", sif.bank_wdata, m_wdata);
    check("q_empty", DATA_W'(sif.q_empty), DATA_W'(m_empty()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, DATA_W'(sif.bank_rd), '0);
    check({tag, "_wr"}, DATA_W'(sif.bank_wr), '0);
    check({tag, "_addr"}, DATA_W'(sif.bank_addr), '0);
    check({tag, "_ocid"}, DATA_W'(sif.bank_ocid), '0);
    check({tag, "_wdata"}, sif.bank_wdata, '0);
    check({tag, "_qempty"}, DATA_W'(sif.q_empty), DATA_W'(4'hF));
  endtask

  initial begin
    logic rv, wv;
    logic [1:0] rb, wb;

    // Reset held with random inputs toggling.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sif.req_valid = 1'($urandom()); sif.req_bank = 2'($urandom()); sif.req_row = ROW_W'($urandom());
      sif.req_ocid  = OCID_W'($urandom());
      sif.wr_valid  = 1'($urandom()); sif.wr_bank = 2'($urandom()); sif.wr_row = ROW_W'($urandom());
      sif.wr_data   = rand_data();
      @(posedge clk);
      #1;
      check_reset_outputs("rst_hold");
    end
    drive_idle();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_release_req_ready", DATA_W'(sif.req_ready), DATA_W'(1'b1));

    // Single uncontested read: bank2 row5 ocid9.
    step(1'b1, 2'd2, 3'd5, 4'h9, 1'b0, 2'd0, '0, '0);
    idle(1);
    check("single_rd", DATA_W'(sif.bank_rd), DATA_W'(4'b0100));
    check("single_addr", DATA_W'(sif.bank_addr[8:6]), DATA_W'(3'd5));
    check("single_ocid", DATA_W'(sif.bank_ocid[11:8]), DATA_W'(4'h9));
    idle(1);
    check("single_rd_done", DATA_W'(sif.bank_rd), '0);
    check("single_qempty", DATA_W'(sif.q_empty), DATA_W'(4'hF));

    // Fill bank1 under a held write; fifth request sees a full queue.
    for (int i = 0; i < 5; i++) step(1'b1, 2'd1, ROW_W'(i), OCID_W'(i + 1), 1'b1, 2'd1, 3'd7, rand_data());
    check("fill_full", DATA_W'(obs_req_ready), DATA_W'(1'b0));
    for (int k = 0; k < 4; k++) begin
      check("fill_order", DATA_W'({sif.bank_rd[1], sif.bank_addr[5:3]}), DATA_W'({1'b1, 3'(k)}));
      idle(1);
    end
    check("fill_drained", DATA_W'(sif.q_empty[1]), DATA_W'(1'b1));
    idle(2);

    // Starvation bound on bank0.
    step(1'b1, 2'd0, 3'd6, 4'h3, 1'b1, 2'd0, 3'd2, rand_data());
    for (int i = 0; i < LIM; i++) begin
      step(1'b0, 2'd0, '0, '0, 1'b1, 2'd0, 3'd2, rand_data());
      check("starve_wr_ok", DATA_W'(obs_wr_ready), DATA_W'(1'b1));
    end
    step(1'b0, 2'd0, '0, '0, 1'b1, 2'd0, 3'd2, rand_data());
    check("starve_stall", DATA_W'(obs_wr_ready), DATA_W'(1'b0));
    check("starve_rd", DATA_W'(sif.bank_rd[0]), DATA_W'(1'b1));
    check("starve_rd_addr", DATA_W'(sif.bank_addr[2:0]), DATA_W'(3'd6));
    step(1'b0, 2'd0, '0, '0, 1'b1, 2'd0, 3'd2, rand_data());
    check("starve_resume", DATA_W'(obs_wr_ready), DATA_W'(1'b1));
    check("starve_resume_wr", DATA_W'(sif.bank_wr[0]), DATA_W'(1'b1));
    idle(2);

    // Parallel banks: reads pending in 0,1,3 while bank2 is written.
    for (int i = 0; i < 4; i++) step(1'b1, 2'd0, ROW_W'(i), OCID_W'(i), 1'b1, 2'd0, 3'd1, rand_data());
    step(1'b1, 2'd1, 3'd4, 4'd4, 1'b1, 2'd1, 3'd1, rand_data());
    step(1'b1, 2'd1, 3'd5, 4'd5, 1'b1, 2'd1, 3'd1, rand_data());
    step(1'b1, 2'd3, 3'd6, 4'd6, 1'b1, 2'd1, 3'd1, rand_data());
    step(1'b0, 2'd0, '0, '0, 1'b1, 2'd2, 3'd3, rand_data());
    check("par_rd", DATA_W'(sif.bank_rd), DATA_W'(4'b1011));
    check("par_wr", DATA_W'(sif.bank_wr), DATA_W'(4'b0100));
    idle(3);

    // Mid-operation reset with entries queued in bank3.
    for (int i = 0; i < 3; i++) step(1'b1, 2'd3, ROW_W'(i), OCID_W'(i), 1'b1, 2'd3, 3'd4, rand_data());
    drive_idle();
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("midrst_no_rd", DATA_W'(sif.bank_rd), '0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(0, 99) < 60);
      wv = ($urandom_range(0, 99) < 55);
      rb = 2'($urandom());
      wb = ($urandom_range(0, 3) == 0) ? rb : 2'($urandom());
      step(rv, rb, ROW_W'($urandom()), OCID_W'($urandom()), wv, wb, ROW_W'($urandom()), rand_data());
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
